kernel_cc_fifo_param: RTL
=========================

// Module: kernel_cc_fifo_param
// PURPOSE
//   Parametrised ap_fifo-style stream FIFO between kernel_cc dataflow processes.
//   Supports any DEPTH >= 2, including non-power-of-2, using a circular buffer with
//   read/write pointers in place of a shift register.
//   Adds an occupancy count, programmable almost-full/almost-empty flags and optional
//   error flags. Keeps the if_* handshake of the existing FIFOs, so it drops in for them.
// PARAMETERS
//   DATA_WIDTH  32  payload width in bits (>= 1)
//   DEPTH       4   number of entries (>= 2; need not be a power of 2)
//   AF_THRESH   3   if_almost_full asserted when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH   1   if_almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
//   Derived: PTR_W = clog2(DEPTH), CNT_W = clog2(DEPTH+1)
// PORTS
//   clk              in   1           single clock, rising edge
//   reset_n          in   1           asynchronous, active-low reset
//   if_empty_n       out  1           1 = if_dout holds valid head data
//   if_read_ce       in   1           read clock enable
//   if_read          in   1           pop request
//   if_dout          out  DATA_WIDTH  head-of-queue data (first-word fall-through)
//   if_full_n        out  1           1 = a write is accepted
//   if_write_ce      in   1           write clock enable
//   if_write         in   1           push request
//   if_din           in   DATA_WIDTH  push data
//   if_count         out  CNT_W       current occupancy, 0..DEPTH
//   if_almost_full   out  1           count >= AF_THRESH
//   if_almost_empty  out  1           count <= AE_THRESH
//   if_overflow      out  1           sticky: write attempted while full
//   if_underflow     out  1           sticky: read attempted while empty
// BEHAVIOUR
//   - Reset (reset_n=0, asynchronous assert, synchronous release):
//     wr_ptr=rd_ptr=0, count=0, if_empty_n=0, if_full_n=1, if_almost_empty=1,
//     if_almost_full=(AF_THRESH==0), overflow=underflow=0.
//     Storage is not cleared. Reset mid-transfer discards all entries.
//   - Handshake qualifiers: wr = if_write & if_write_ce & if_full_n;
//     rd = if_read & if_read_ce & if_empty_n.
//   - wr: mem[wr_ptr] <= if_din; wr_ptr increments, wrapping DEPTH-1 -> 0.
//   - rd: rd_ptr increments with the same wrap. if_dout = mem[rd_ptr], read combinationally.
//   - Latency: a write into an empty FIFO raises if_empty_n and presents if_dout on the
//     next cycle. A pop frees a slot, and if_full_n rises on the next cycle.
//   - Counter: wr&!rd -> count+1; rd&!wr -> count-1; wr&rd or neither -> unchanged.
//   - Simultaneous read and write:
//     - When full: only rd qualifies (if_full_n=0), so count drops to DEPTH-1.
//     - When empty: only wr qualifies, so count becomes 1.
//     - Otherwise both occur and count holds.
//   - All status outputs are registered and computed from next-count:
//     if_empty_n=(next!=0), if_full_n=(next!=DEPTH), and the almost flags per thresholds.
//   - No combinational path from any input to if_empty_n, if_full_n, if_count or the
//     almost flags.
//   - Unqualified push when full: dropped, with no state change.
//     Unqualified pop when empty: ignored, and if_dout is don't-care.
// CONFIGURATION
//   KERNEL_CC_FIFO_ERR_EN defined: if_overflow sets on (if_write & if_write_ce & !if_full_n)
//     and if_underflow sets on (if_read & if_read_ce & !if_empty_n). Both are sticky and
//     clear only on reset.
//   Not defined: if_overflow and if_underflow are tied to 0 and no flops are inferred.
// STRUCTURE
//   Package kernel_cc_fifo_pkg:
//     - clog2 constant function
//     - ptr_inc(ptr, depth) wrap function
//     - localparams for CNT_W and PTR_W derivation
//   Sub-module kernel_cc_fifo_param_mem: DEPTH x DATA_WIDTH array with one sync write
//     port (we, waddr, wdata) and one async read port (raddr, rdata). Infers LUTRAM or
//     registers.
//   Top level holds the pointers, counter, flag registers and the optional error logic.
// TESTING (DEPTH=5, DATA_WIDTH=32, AF_THRESH=4, AE_THRESH=1)
//   1. Reset -> if_empty_n=0, if_full_n=1, if_count=0, if_almost_empty=1, if_almost_full=0.
//   2. Push 0xA0..0xA4 on consecutive cycles -> if_count 1..5, if_almost_full at count 4,
//      if_full_n=0 after the 5th push. Pop 5 -> if_dout A0..A4 in order, ending empty.
//   3. Wrap: push 3, pop 3, then push 5 more -> pointers wrap past index 4 and output
//      order is preserved.
//   4. Read and write together at count 2 -> count stays 2. At full, read and write
//      together -> count=4, pushed data dropped. At empty, both -> count=1, data retained.
//   5. Drop reset_n asynchronously mid-stream at count 3 -> flags return to reset values
//      with no clock edge. A subsequent push of 0x55 reads back 0x55.
//   6. With KERNEL_CC_FIFO_ERR_EN: push while full -> if_overflow=1 and stays set.
//      Pop while empty -> if_underflow=1. Without the macro, both remain 0.

Source files
------------

// File: rtl/kernel_cc_fifo_pkg.sv
// Shared helpers for the kernel_cc parametrised stream FIFO.
// Width derivation and circular pointer wrap.
package kernel_cc_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_AF_THRESH  = 3;
  localparam int DEF_AE_THRESH  = 1;

  // Bits needed to encode values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic int ptr_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

  // Advance a circular-buffer pointer, wrapping depth-1 -> 0.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/kernel_cc_fifo_param_mem.sv
// Storage array for the kernel_cc FIFO.
// One synchronous write port, one asynchronous read port.
module kernel_cc_fifo_param_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int AW         = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; contents are deliberately left uninitialised.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/kernel_cc_fifo_param.sv
// Circular-buffer stream FIFO with count and almost flags.
// Define KERNEL_CC_FIFO_ERR_EN for sticky overflow/underflow flags.
module kernel_cc_fifo_param
  import kernel_cc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_THRESH  = DEF_AF_THRESH,
  parameter int AE_THRESH  = DEF_AE_THRESH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  output logic                       if_empty_n,
  input  logic                       if_read_ce,
  input  logic                       if_read,
  output logic [DATA_WIDTH-1:0]      if_dout,
  output logic                       if_full_n,
  input  logic                       if_write_ce,
  input  logic                       if_write,
  input  logic [DATA_WIDTH-1:0]      if_din,
  output logic [cnt_w(DEPTH)-1:0]    if_count,
  output logic                       if_almost_full,
  output logic                       if_almost_empty,
  output logic                       if_overflow,
  output logic                       if_underflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wr, rd;

  assign wr = if_write & if_write_ce & if_full_n;
  assign rd = if_read & if_read_ce & if_empty_n;

  kernel_cc_fifo_param_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (PTR_W)
  ) u_mem (
    .clk  (clk),
    .we   (wr),
    .waddr(wr_ptr),
    .wdata(if_din),
    .raddr(rd_ptr),
    .rdata(if_dout)
  );

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    cnt_nxt    = if_count;
    if (wr) wr_ptr_nxt = PTR_W'(ptr_inc(int'(wr_ptr), DEPTH));
    if (rd) rd_ptr_nxt = PTR_W'(ptr_inc(int'(rd_ptr), DEPTH));
    unique case (1'b1)
      (wr & ~rd): cnt_nxt = if_count + CNT_W'(1);
      (rd & ~wr): cnt_nxt = if_count - CNT_W'(1);
      default:    cnt_nxt = if_count;
    endcase
  end

  // Pointers, count and status flags, all registered off next-count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      if_count        <= '0;
      if_empty_n      <= 1'b0;
      if_full_n       <= 1'b1;
      if_almost_full  <= (AF_THRESH == 0);
      if_almost_empty <= 1'b1;
    end else begin
      wr_ptr          <= wr_ptr_nxt;
      rd_ptr          <= rd_ptr_nxt;
      if_count        <= cnt_nxt;
      if_empty_n      <= (cnt_nxt != '0);
      if_full_n       <= (cnt_nxt != CNT_W'(DEPTH));
      if_almost_full  <= (int'(cnt_nxt) >= AF_THRESH);
      if_almost_empty <= (int'(cnt_nxt) <= AE_THRESH);
    end
  end

`ifdef KERNEL_CC_FIFO_ERR_EN
  logic ovf_q, udf_q;

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (if_write & if_write_ce & ~if_full_n) ovf_q <= 1'b1;
      if (if_read & if_read_ce & ~if_empty_n)  udf_q <= 1'b1;
    end
  end

  assign if_overflow  = ovf_q;
  assign if_underflow = udf_q;
`else
  assign if_overflow  = 1'b0;
  assign if_underflow = 1'b0;
`endif

endmodule
